// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine magnitude: 257-point table with 32-step linear interpolation,
// two register stages from phase index v to magnitude sv.
module sine_quarter_lut #(
  parameter int LATENCY = 2,
  parameter int AMP     = 32767
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] v,
  output logic [15:0] sv
);

  if (LATENCY != 2) begin : g_bad_latency
    $error("sine_quarter_lut only supports LATENCY = 2");
  end

  localparam longint PI_Q30 = 64'sd3373259426;  // round(pi * 2^30)

  // Knot k sits at index 32k, angle (64k+1)*pi/32768; Taylor series in Q30.
  function automatic int sine_point(input int k);
    longint x;
    longint x2;
    longint term;
    longint acc;
    longint scaled;
    x    = ((64 * longint'(k) + 1) * PI_Q30) / 32768;
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int n = 1; n <= 10; n++) begin
      term = ((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      if (n % 2 == 1) acc = acc - term;
      else            acc = acc + term;
    end
    scaled = (acc * longint'(AMP) + 64'sd536870912) >>> 30;
    if (scaled > longint'(AMP)) scaled = longint'(AMP);
    if (scaled < 0) scaled = 0;
    return int'(scaled);
  endfunction

  logic [14:0] rom [0:256];

  for (genvar gi = 0; gi <= 256; gi++) begin : g_rom
    localparam int POINT = sine_point(gi);
    assign rom[gi] = 15'(POINT);
  end

  logic [14:0] base_reg;
  logic [14:0] next_reg;
  logic [4:0]  frac_reg;
  logic [15:0] sv_reg;
  logic [14:0] diff;
  logic [19:0] prod;
  logic [14:0] step;
  logic [15:0] sv_next;

  // Stage 1: registered read of the two knots bracketing v.
  always_ff @(posedge clk) begin
    if (!rst) begin
      base_reg <= '0;
      next_reg <= '0;
      frac_reg <= '0;
    end else begin
      base_reg <= rom[{1'b0, v[12:5]}];
      next_reg <= rom[{1'b0, v[12:5]} + 9'd1];
      frac_reg <= v[4:0];
    end
  end

  // Knots are non-decreasing, so diff never wraps and the result stays within [base, next].
  always_comb begin
    diff    = next_reg - base_reg;
    prod    = 20'(diff) * 20'(frac_reg);
    step    = 15'((prod + 20'd16) >> 5);
    sv_next = {1'b0, base_reg + step};
  end

  // Stage 2: output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sv_reg <= '0;
    end else begin
      sv_reg <= sv_next;
    end
  end

  assign sv = sv_reg;

endmodule

// File: tb/tb_sine_quarter_lut.sv
// Self-checking bench for sine_quarter_lut: expectations are queued with their due
// edge when stimulus is driven and checked against sv once that edge has passed.
module tb_sine_quarter_lut;

  logic        clk;
  logic        rst;
  logic [12:0] v;
  logic [15:0] sv;

  sine_quarter_lut #(.LATENCY(2), .AMP(32767)) dut (
    .clk(clk),
    .rst(rst),
    .v  (v),
    .sv (sv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    int lo;
    int hi;
    int vtag;
  } exp_t;

  typedef struct {
    int v;
    int lo;
    int hi;
  } vec_t;

  exp_t exp_q[$];
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   last_v;
  int   last_sv;

  localparam real PI = 3.14159265358979323846;

  function automatic int ideal_sin(input int vv);
    real th;
    th = (real'(vv) + 0.5) * PI / 16384.0;
    return $rtoi(32767.0 * $sin(th) + 0.5);
  endfunction

  function automatic int ideal_cos(input int vv);
    real th;
    th = (real'(vv) + 0.5) * PI / 16384.0;
    return $rtoi(32767.0 * $cos(th) + 0.5);
  endfunction

  function automatic int clamp(input int x);
    if (x < 0) return 0;
    if (x > 32767) return 32767;
    return x;
  endfunction

  task automatic check_due();
    exp_t e;
    int   s;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      s = int'(sv);
      n_checks++;
      if (e.due != cyc || s < e.lo || s > e.hi) begin
        n_fail++;
        $display("FAIL sv v=%0d cycle=%0d: got %0d, required %0d..%0d", e.vtag, cyc, s, e.lo, e.hi);
      end else begin
        $display("cycle %0d v=%0d sv=%0d ok (%0d..%0d)", cyc, e.vtag, s, e.lo, e.hi);
      end
      if (e.vtag >= 0) begin
        n_checks++;
        if (sv[15] !== 1'b0) begin
          n_fail++;
          $display("FAIL sign_bit v=%0d: got %0b, required 0", e.vtag, sv[15]);
        end
        if (last_v >= 0 && e.vtag == last_v + 1) begin
          n_checks++;
          if (s < last_sv) begin
            n_fail++;
            $display("FAIL monotonic v=%0d: got %0d, required >= %0d", e.vtag, s, last_sv);
          end
        end
        last_v  = e.vtag;
        last_sv = s;
      end
    end
  endtask

  // One clock: apply rst/v, record what the DUT owes and when, then check.
  task automatic step(input logic r, input int vin, input int lo, input int hi);
    exp_t e;
    rst = r;
    v   = 13'(vin);
    if (!r) begin
      foreach (exp_q[i]) begin
        if (exp_q[i].due >= cyc + 1) begin
          exp_q[i].lo   = 0;
          exp_q[i].hi   = 0;
          exp_q[i].vtag = -1;
        end
      end
      e = '{due: cyc + 1, lo: 0, hi: 0, vtag: -1};
      exp_q.push_back(e);
      e = '{due: cyc + 2, lo: 0, hi: 0, vtag: -1};
      exp_q.push_back(e);
      last_v = -1;
    end else begin
      e = '{due: cyc + 2, lo: lo, hi: hi, vtag: vin};
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
    check_due();
  endtask

  task automatic step_ideal(input int vin);
    int id;
    id = ideal_sin(vin);
    step(1'b1, vin, clamp(id - 2), clamp(id + 2));
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      check_due();
    end
  endtask

  vec_t key_tab[4];
  int   mirror_v[6];

  initial begin
    key_tab[0] = '{v: 0,    lo: 1,     hi: 5};
    key_tab[1] = '{v: 2730, lo: 16381, hi: 16385};
    key_tab[2] = '{v: 4096, lo: 23170, hi: 23174};
    key_tab[3] = '{v: 8191, lo: 32765, hi: 32767};
    mirror_v   = '{0, 4095, 1000, 3000, 6000, 8191};

    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    last_v   = -1;
    last_sv  = 0;
    rst      = 1'b0;
    v        = 13'd8191;
    @(posedge clk);
    #1;
    cyc++;

    // Reset held for 3 clocks, then released with v held at full scale.
    for (int i = 0; i < 3; i++) step(1'b0, 8191, 0, 0);
    step(1'b1, 8191, 32765, 32767);
    step(1'b1, 8191, 32765, 32767);

    // Key points back to back.
    for (int i = 0; i < 4; i++) step(1'b1, key_tab[i].v, key_tab[i].lo, key_tab[i].hi);

    // Latency: 0, 4096, 8191, 0 on consecutive clocks.
    step(1'b1, 0,    key_tab[0].lo, key_tab[0].hi);
    step(1'b1, 4096, key_tab[2].lo, key_tab[2].hi);
    step(1'b1, 8191, key_tab[3].lo, key_tab[3].hi);
    step(1'b1, 0,    key_tab[0].lo, key_tab[0].hi);

    // Mirror: index 8191-v against the cosine of theta(v).
    for (int i = 0; i < 6; i++) begin
      int c;
      c = ideal_cos(mirror_v[i]);
      step(1'b1, 8191 - mirror_v[i], clamp(c - 2), clamp(c + 2));
    end
    drain();

    // Exhaustive sweep.
    last_v = -1;
    for (int vv = 0; vv < 8192; vv++) step_ideal(vv);
    drain();

    // Mid-stream reset pulse inside a short sweep.
    last_v = -1;
    for (int vv = 5000; vv < 5030; vv++) begin
      if (vv == 5010) step(1'b0, vv, 0, 0);
      else            step_ideal(vv);
    end
    drain();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sine_quarter_lut.md
Name: sine_quarter_lut

Overview:
Pipelined quarter-wave sine generator used by the DDS correlator channels.
- Input: a 13-bit quarter-wave phase index, sampled every clock.
- Output: the non-negative 16-bit sine magnitude for that index.
- Quadrant folding and sign negation stay in the caller. The caller feeds the phase MSBs directly, or bit-inverted for odd quadrants, and negates the result for the lower half-wave.

Parameters:
LATENCY, 2, clocks from v sample to sv update; fixed, any other value unsupported.
AMP, 32767, full-scale output amplitude.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, synchronous, active-low (0 = reset)
v    input  13  quarter-wave phase index, 0..8191
sv   output 16  sine magnitude, unsigned, bit 15 always 0

Behaviour:
- Angle definition: index v represents theta(v) = (v + 0.5) * (pi/2) / 8192.
  - The half-LSB offset makes index ~v (8191 - v) the exact mirror: theta(8191 - v) = pi/2 - theta(v).
- Ideal value: ideal(v) = round(AMP * sin(theta(v))).
- Required accuracy: |sv - ideal(v)| <= 2 LSB for every v.
- Monotonic: sv(v+1) >= sv(v) for all v in 0..8190.
- Range: sv never exceeds 32767, so bit 15 is always 0. The caller sign-extends bit 15.
- Implementation method is free: a full ROM init file, a coarse table with linear interpolation, or a polynomial. Accuracy, monotonicity and latency rules above are binding.
- Timing: fully pipelined.
  - A new v is accepted every clock with no handshake.
  - sv presents the result for the v sampled exactly 2 rising edges earlier.
  - No combinational path from v to sv.
- Reset:
  - On a rising edge with rst=0, all pipeline registers clear and sv = 0.
  - While rst is held low, sv stays 0.
  - Assertion mid-stream discards in-flight lookups.
- After release: the first edge with rst=1 samples v. sv = 0 until the second edge after release, then it carries valid results.
- Unknown or X on v is not supported. Outputs for X inputs are undefined but must not disturb later lookups.
- Stateless apart from the pipeline: results depend only on the sampled index, never on history.

Test Plan:
- Reset: hold rst=0 for 3 clocks with v=8191 -> sv=0 on every edge. Release rst, keep v=8191 -> sv=0 after edge 1, sv in 32765..32767 after edge 2.
- Key points, one per clock, each checked 2 clocks later:
  - v=0 -> sv in 1..5
  - v=2730 -> sv in 16381..16385
  - v=4096 -> sv in 23170..23174
  - v=8191 -> sv in 32765..32767
- Latency and back-to-back: drive v=0,4096,8191,0 on consecutive clocks -> sv sequence lags exactly 2 clocks, with no repeated or skipped values.
- Exhaustive sweep of v=0..8191:
  - every |sv - ideal(v)| <= 2
  - sv non-decreasing
  - sv[15]=0 throughout
- Mirror check: for sampled v, sv(8191 - v) matches round(AMP*cos(theta(v))) within 2 LSB; e.g. v=0 with 8191, v=4095 with 4096 (both 23167..23174).
- Mid-stream reset: during the sweep, pull rst=0 for 1 clock -> sv=0 on that edge and the next edge. Correct values for new v resume 2 clocks after release.
